// File: rtl/inst_dispatch_if.sv
// inst_dispatch_if: fetch-side handshake and back-end issue bus of the dispatch stage.
interface inst_dispatch_if #(
    parameter int TAG_W = 4
);
    logic             if_valid;
    logic             if_ready;
    logic [31:0]      if_inst;
    logic [31:0]      if_pc;
    logic             if_pred;
    logic             rob_full;
    logic             rs_full;
    logic             lsb_full;
    logic [TAG_W-1:0] rob_tail;
    logic             rob_valid;
    logic             rs_valid;
    logic             lsb_valid;
    logic [31:0]      d_inst;
    logic [31:0]      d_pc;
    logic             d_pred;
    logic [TAG_W-1:0] d_tag;
    modport master (
        output if_valid, if_inst, if_pc, if_pred, rob_full, rs_full, lsb_full, rob_tail,
        input  if_ready, rob_valid, rs_valid, lsb_valid, d_inst, d_pc, d_pred, d_tag
    );
    modport slave (
        input  if_valid, if_inst, if_pc, if_pred, rob_full, rs_full, lsb_full, rob_tail,
        output if_ready, rob_valid, rs_valid, lsb_valid, d_inst, d_pc, d_pred, d_tag
    );
endinterface

// File: rtl/inst_dispatch.sv
// inst_dispatch: in-order instruction queue issuing to RS/LSB while claiming the ROB tail.
// Define DISPATCH_BYPASS_EN to let a fetch skip the empty queue and issue at the same edge.
module inst_dispatch #(
    parameter int DEPTH = 16,
    parameter int TAG_W = 4
) (
    input logic            clk_in,
    input logic            rst_in,
    input logic            rdy_in,
    input logic            flush,
    inst_dispatch_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    logic [64:0]   mem [DEPTH];
    logic [AW-1:0] head, tail;
    logic [AW:0]   count;
    logic [64:0]   head_e, in_e, sel_e;
    logic          run, head_ok, in_ok, bypass, push, pop, fire, sel_ls;

    function automatic logic is_ls(input logic [31:0] i);
        return i[6:0] == 7'b0000011 || i[6:0] == 7'b0100011;
    endfunction

    assign head_e = mem[head];
    assign in_e = {bus.if_inst, bus.if_pc, bus.if_pred};
    assign run = rdy_in && !flush;
    assign bus.if_ready = count != (AW+1)'(DEPTH);
    assign head_ok = count != '0 && !bus.rob_full &&
                     (is_ls(head_e[64:33]) ? !bus.lsb_full : !bus.rs_full);
`ifdef DISPATCH_BYPASS_EN
    assign in_ok = count == '0 && bus.if_valid && !bus.rob_full &&
                   (is_ls(bus.if_inst) ? !bus.lsb_full : !bus.rs_full);
`else
    assign in_ok = 1'b0;
`endif
    assign bypass = run && in_ok;
    assign pop = run && head_ok;
    assign push = run && bus.if_valid && bus.if_ready && !in_ok;
    assign fire = pop || bypass;
    assign sel_e = bypass ? in_e : head_e;
    assign sel_ls = is_ls(sel_e[64:33]);

    always_ff @(posedge clk_in) begin
        if (push) mem[tail] <= in_e;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head <= '0;
            tail <= '0;
            count <= '0;
            bus.rob_valid <= 1'b0;
            bus.rs_valid <= 1'b0;
            bus.lsb_valid <= 1'b0;
            bus.d_inst <= '0;
            bus.d_pc <= '0;
            bus.d_pred <= 1'b0;
            bus.d_tag <= '0;
        end else if (rdy_in) begin
            if (flush) begin
                head <= '0;
                tail <= '0;
                count <= '0;
                bus.rob_valid <= 1'b0;
                bus.rs_valid <= 1'b0;
                bus.lsb_valid <= 1'b0;
            end else begin
                if (push) tail <= tail + AW'(1);
                if (pop) head <= head + AW'(1);
                count <= count + (AW+1)'(push) - (AW+1)'(pop);
                bus.rob_valid <= fire;
                bus.rs_valid <= fire && !sel_ls;
                bus.lsb_valid <= fire && sel_ls;
                // Data outputs keep the last issued instruction between issues.
                if (fire) begin
                    {bus.d_inst, bus.d_pc, bus.d_pred} <= sel_e;
                    bus.d_tag <= bus.rob_tail;
                end
            end
        end
    end
endmodule

// File: tb/tb_inst_dispatch.sv
// tb_inst_dispatch: scoreboard-checked bench for inst_dispatch, class table plus corner sequences.
module tb_inst_dispatch;
    localparam int DEPTH = 16;
    localparam int TAG_W = 4;
`ifdef DISPATCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        pred;
        logic        ls;
    } exp_t;
    typedef struct {
        logic [31:0] inst;
        logic        ls;
    } vec_t;

    logic clk_in = 1'b0, rst_in = 1'b1, rdy_in = 1'b1, flush = 1'b0;
    logic drv_ls = 1'b0;
    logic live = 1'b0;
    logic [TAG_W-1:0] tag_snap = '0;
    exp_t sb[$];
    int total = 0, bad = 0, n_iss = 0;

    always #5 clk_in = ~clk_in;

    inst_dispatch_if #(.TAG_W(TAG_W)) bus ();
    inst_dispatch #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush), .bus(bus.slave)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    // Inputs are stable at the edge; drivers change them 1 time unit later.
    always @(posedge clk_in) begin
        tag_snap = bus.rob_tail;
        live = !rst_in && rdy_in;
        if (rst_in || (rdy_in && flush)) sb.delete();
        else if (rdy_in && bus.if_valid && bus.if_ready)
            sb.push_back('{bus.if_inst, bus.if_pc, bus.if_pred, drv_ls});
    end

    always @(negedge clk_in) begin
        if (live) begin
            if (bus.rob_valid) begin
                exp_t e;
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL spurious_issue: got pc %0h want no issue", bus.d_pc);
                end else begin
                    e = sb.pop_front();
                    n_iss++;
                    check("d_inst", bus.d_inst, e.inst);
                    check("d_pc", bus.d_pc, e.pc);
                    check("d_pred", bus.d_pred, e.pred);
                    check("d_tag", bus.d_tag, tag_snap);
                    check("unit", {bus.rs_valid, bus.lsb_valid}, e.ls ? 2'b01 : 2'b10);
                end
            end else check("stray_valid", {bus.rs_valid, bus.lsb_valid}, 2'b00);
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
        bus.rob_tail = bus.rob_tail + 1'b1;
    endtask

    task automatic offer(input logic [31:0] i, input logic [31:0] p, input logic pr, input logic ls);
        bus.if_valid = 1'b1;
        bus.if_inst = i;
        bus.if_pc = p;
        bus.if_pred = pr;
        drv_ls = ls;
    endtask

    task automatic drain();
        for (int k = 0; k < 64 && sb.size() != 0; k++) step();
        check("drain", sb.size(), 0);
        step();
    endtask

    vec_t tbl[14];
    int n0;

    initial begin
        tbl = '{'{32'h0000A103, 1'b1}, '{32'h0020A023, 1'b1}, '{32'h002081B3, 1'b0},
                '{32'h00208063, 1'b0}, '{32'h0000006F, 1'b0}, '{32'h000000B7, 1'b0},
                '{32'hFFFFFFFF, 1'b0}, '{32'h00000003, 1'b1}, '{32'h00000023, 1'b1},
                '{32'h00000000, 1'b0}, '{32'h00000013, 1'b0}, '{32'h00000027, 1'b0},
                '{32'h00000007, 1'b0}, '{32'h00412083, 1'b1}};
        bus.if_valid = 1'b0; bus.if_inst = '0; bus.if_pc = '0; bus.if_pred = 1'b0;
        bus.rob_full = 1'b0; bus.rs_full = 1'b0; bus.lsb_full = 1'b0; bus.rob_tail = 4'd3;
        repeat (2) step();
        rst_in = 1'b0;
        check("rst_rob_valid", bus.rob_valid, 0);
        check("rst_rs_valid", bus.rs_valid, 0);
        check("rst_lsb_valid", bus.lsb_valid, 0);
        check("rst_d", {bus.d_inst, bus.d_pc, bus.d_pred, bus.d_tag}, 0);
        check("rst_if_ready", bus.if_ready, 1);

        offer(32'h00100093, 32'h0, 1'b0, 1'b0);
        step();
        bus.if_valid = 1'b0;
        check("lat_e0", bus.rob_valid, BYP);
        step();
        check("lat_e1", bus.rob_valid, !BYP);
        step();
        check("pulse_end", bus.rob_valid, 0);
        check("d_hold", bus.d_inst, 32'h00100093);

        for (int i = 0; i < 14; i++) begin
            offer(tbl[i].inst, 32'h100 + 32'(i * 4), i[0], tbl[i].ls);
            step();
        end
        bus.if_valid = 1'b0;
        drain();

        bus.lsb_full = 1'b1;
        offer(32'h0000A103, 32'h200, 1'b0, 1'b1);
        step();
        offer(32'h002081B3, 32'h204, 1'b1, 1'b0);
        step();
        bus.if_valid = 1'b0;
        check("lsb_block0", bus.rob_valid, 0);
        step();
        check("lsb_block1", bus.rob_valid, 0);
        bus.lsb_full = 1'b0;
        step();
        check("lw_issue", {bus.lsb_valid, bus.d_inst}, {1'b1, 32'h0000A103});
        step();
        check("add_issue", {bus.rs_valid, bus.d_inst}, {1'b1, 32'h002081B3});
        drain();

        bus.rob_full = 1'b1;
        for (int i = 0; i < 16; i++) begin
            offer(32'h00000013 + 32'(i << 20), 32'h1000 + 32'(i * 4), 1'b0, 1'b0);
            step();
        end
        check("full_ready", bus.if_ready, 0);
        offer(32'h00000013, 32'hDEAD, 1'b0, 1'b0);
        step();
        bus.if_valid = 1'b0;
        check("full_hold", bus.if_ready, 0);
        bus.rob_full = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            check("wrap_pc", {bus.rob_valid, bus.d_pc}, {1'b1, 32'h1000 + 32'(i * 4)});
        end
        step();
        check("wrap_done", bus.rob_valid, 0);

        bus.rob_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            offer(32'h00000013, 32'h6000 + 32'(i * 4), 1'b0, 1'b0);
            step();
        end
        bus.if_valid = 1'b0;
        bus.rob_full = 1'b0;
        step();
        check("pre_flush_issue", bus.rob_valid, 1);
        flush = 1'b1;
        offer(32'h00000013, 32'h6FFC, 1'b0, 1'b0);
        step();
        flush = 1'b0;
        bus.if_valid = 1'b0;
        check("flush_valids", {bus.rob_valid, bus.rs_valid, bus.lsb_valid}, 0);
        check("flush_ready", bus.if_ready, 1);
        repeat (4) begin
            step();
            check("flush_quiet", bus.rob_valid, 0);
        end

        n0 = n_iss;
        for (int i = 0; i < 12; i++) begin
            offer(32'h00000013, 32'h5000 + 32'(i * 4), 1'b0, 1'b0);
            if (i == 6) begin
                rdy_in = 1'b0;
                repeat (4) begin
                    step();
                    check("frz_pc", {bus.rob_valid, bus.d_pc}, {1'b1, 32'h5000 + 32'((5 - int'(!BYP)) * 4)});
                    check("frz_ready", bus.if_ready, 1);
                end
                rdy_in = 1'b1;
            end
            step();
        end
        bus.if_valid = 1'b0;
        drain();
        check("rdy_count", n_iss - n0, 12);

        bus.rob_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            offer(32'h00000013, 32'h4000 + 32'(i * 4), 1'b0, 1'b0);
            step();
        end
        bus.rob_full = 1'b0;
        for (int k = 0; k < 32; k++) begin
            offer(32'h00000013, 32'h4000 + 32'((k + 3) * 4), 1'b0, 1'b0);
            step();
            check("mix_pc", {bus.rob_valid, bus.d_pc}, {1'b1, 32'h4000 + 32'(k * 4)});
        end
        bus.if_valid = 1'b0;
        drain();

        bus.rob_full = 1'b1;
        for (int i = 0; i < 2; i++) begin
            offer(32'h00000013, 32'h7000 + 32'(i * 4), 1'b0, 1'b0);
            step();
        end
        bus.if_valid = 1'b0;
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        bus.rob_full = 1'b0;
        check("mid_rst_ready", bus.if_ready, 1);
        repeat (3) begin
            step();
            check("mid_rst_quiet", bus.rob_valid, 0);
        end
        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
